// File: rtl/b_type_predictor_pkg.sv
// Shared encodings and types for the B-type branch direction predictor.
// Counter encodings follow the legacy define.v names so existing code can migrate unchanged.
package b_type_predictor_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT     = 2'b00;
  localparam ctr_t WNT     = 2'b01;
  localparam ctr_t WT      = 2'b10;
  localparam ctr_t ST      = 2'b11;
  localparam ctr_t CNT_RST = WNT;

  localparam logic        zero     = 1'b0;
  localparam logic [31:0] zeroword = 32'h0000_0000;

endpackage

// File: rtl/b_type_predictor_if.sv
// Lookup (ID), update (EX) and perf-counter signals of the branch predictor.
// master = pipeline side, slave = predictor side.
interface b_type_predictor_if #(
  parameter int INDEX_BITS = 6
);
  logic                  lookup_valid_i;
  logic [31:0]           lookup_pc_i;
  logic                  PL_stall;
  logic                  prediction_o;
  logic [INDEX_BITS-1:0] pred_history_o;
  logic                  update_valid_i;
  logic [31:0]           update_pc_i;
  logic                  update_taken_i;
  logic                  update_mispredict_i;
  logic [INDEX_BITS-1:0] update_history_i;
  logic [31:0]           branch_cnt_o;
  logic [31:0]           mispredict_cnt_o;

  modport master (
    output lookup_valid_i, lookup_pc_i, PL_stall,
    output update_valid_i, update_pc_i, update_taken_i, update_mispredict_i, update_history_i,
    input  prediction_o, pred_history_o, branch_cnt_o, mispredict_cnt_o
  );

  modport slave (
    input  lookup_valid_i, lookup_pc_i, PL_stall,
    input  update_valid_i, update_pc_i, update_taken_i, update_mispredict_i, update_history_i,
    output prediction_o, pred_history_o, branch_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/b_type_predictor_sat_counter_next.sv
// Combinational next state of a 2-bit saturating direction counter.
module bp_sat_counter_next
  import b_type_predictor_pkg::*;
(
  input  ctr_t cnt_i,
  input  logic taken_i,
  output ctr_t cnt_o
);
  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST)  cnt_o = cnt_i + 2'b01;
    end else begin
      if (cnt_i != SNT) cnt_o = cnt_i - 2'b01;
    end
  end
endmodule

// File: rtl/b_type_predictor.sv
// Bimodal / gshare direction predictor for B-type branches: ID lookup, EX training.
// Define B_TYPE_PREDICTOR_GSHARE_EN to add the speculative global history register.
module b_type_predictor
  import b_type_predictor_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  b_type_predictor_if.slave   bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  typedef logic [INDEX_BITS-1:0] idx_t;

  ctr_t        tbl_q [ENTRIES];
  ctr_t        tbl_d [ENTRIES];
  idx_t        hist, lkp_idx, upd_idx;
  ctr_t        upd_cur, upd_nxt;
  logic        pred;
  logic        mispredict_evt;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  assign mispredict_evt = bp.update_valid_i && bp.update_mispredict_i;

`ifdef B_TYPE_PREDICTOR_GSHARE_EN
  idx_t ghr_q, ghr_d;
  logic unused_bits;

  assign hist    = ghr_q;
  assign upd_idx = bp.update_pc_i[INDEX_BITS+1:2] ^ bp.update_history_i;

  // Repair wins over the speculative shift: the younger lookup is being flushed.
  always_comb begin
    ghr_d = ghr_q;
    if (mispredict_evt)
      ghr_d = {bp.update_history_i[INDEX_BITS-2:0], bp.update_taken_i};
    else if (bp.lookup_valid_i && !bp.PL_stall)
      ghr_d = {ghr_q[INDEX_BITS-2:0], pred};
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  assign unused_bits = ^{bp.lookup_pc_i[31:INDEX_BITS+2], bp.lookup_pc_i[1:0],
                         bp.update_pc_i[31:INDEX_BITS+2], bp.update_pc_i[1:0]};
`else
  logic unused_bits;

  assign hist    = '0;
  assign upd_idx = bp.update_pc_i[INDEX_BITS+1:2];

  assign unused_bits = ^{bp.lookup_pc_i[31:INDEX_BITS+2], bp.lookup_pc_i[1:0],
                         bp.update_pc_i[31:INDEX_BITS+2], bp.update_pc_i[1:0],
                         bp.PL_stall, bp.update_history_i};
`endif

  assign lkp_idx           = bp.lookup_pc_i[INDEX_BITS+1:2] ^ hist;
  assign pred              = tbl_q[lkp_idx][1] & bp.lookup_valid_i;
  assign bp.prediction_o   = pred;
  assign bp.pred_history_o = hist;

  assign upd_cur = tbl_q[upd_idx];

  bp_sat_counter_next u_sat (
    .cnt_i   (upd_cur),
    .taken_i (bp.update_taken_i),
    .cnt_o   (upd_nxt)
  );

  // Lookup reads tbl_q directly, so a same-cycle update to its entry is not bypassed.
  always_comb begin
    tbl_d = tbl_q;
    if (bp.update_valid_i) tbl_d[upd_idx] = upd_nxt;
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q + {31'b0, bp.update_valid_i};
    mispredict_cnt_d = mispredict_cnt_q + {31'b0, mispredict_evt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= CNT_RST;
      branch_cnt_q     <= zeroword;
      mispredict_cnt_q <= zeroword;
    end else begin
      tbl_q            <= tbl_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bp.branch_cnt_o     = branch_cnt_q;
  assign bp.mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_b_type_predictor.sv
// Directed + random bench for b_type_predictor with a reference model feeding a scoreboard.
// Follows B_TYPE_PREDICTOR_GSHARE_EN so the model matches the build under test.
module tb_b_type_predictor;

`ifdef B_TYPE_PREDICTOR_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  b_type_predictor_if #(.INDEX_BITS(6)) bp_if ();

  b_type_predictor #(.INDEX_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if.slave)
  );

  typedef struct packed {
    logic        pred;
    logic [5:0]  hist;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t        sb [$];
  logic [1:0]  m_tbl [64];
  logic [5:0]  m_ghr;
  logic [31:0] m_bc, m_mc;
  int          errs   = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = 2'b01;
    m_ghr = '0;
    m_bc  = '0;
    m_mc  = '0;
  endtask

  task automatic step(input string tag, input logic r,
                      input logic lv, input logic [31:0] lpc, input logic st,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic um, input logic [5:0] uh);
    exp_t       e;
    logic [5:0] li, ui;
    logic       p;
    @(negedge clk);
    rst                       = r;
    bp_if.lookup_valid_i      = lv;
    bp_if.lookup_pc_i         = lpc;
    bp_if.PL_stall            = st;
    bp_if.update_valid_i      = uv;
    bp_if.update_pc_i         = upc;
    bp_if.update_taken_i      = ut;
    bp_if.update_mispredict_i = um;
    bp_if.update_history_i    = uh;
    li = lpc[7:2] ^ (GS ? m_ghr : 6'd0);
    p  = lv & m_tbl[li][1];
    e  = '{pred: p, hist: (GS ? m_ghr : 6'd0), bc: m_bc, mc: m_mc};
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({tag, ".pred"}, {31'b0, bp_if.prediction_o},  {31'b0, e.pred});
    chk({tag, ".hist"}, {26'b0, bp_if.pred_history_o}, {26'b0, e.hist});
    chk({tag, ".bcnt"}, bp_if.branch_cnt_o,     e.bc);
    chk({tag, ".mcnt"}, bp_if.mispredict_cnt_o, e.mc);
    // model state for the coming posedge
    if (r) model_reset();
    else begin
      ui = upc[7:2] ^ (GS ? uh : 6'd0);
      if (uv) begin
        if (ut) m_tbl[ui] = (m_tbl[ui] == 2'b11) ? 2'b11 : m_tbl[ui] + 2'b01;
        else    m_tbl[ui] = (m_tbl[ui] == 2'b00) ? 2'b00 : m_tbl[ui] - 2'b01;
        m_bc = m_bc + 32'd1;
        if (um) m_mc = m_mc + 32'd1;
      end
      if (GS) begin
        if (uv && um)          m_ghr = {uh[4:0], ut};
        else if (lv && !st)    m_ghr = {m_ghr[4:0], p};
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pcs [6];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200;
    pcs[3] = 32'h300; pcs[4] = 32'h040; pcs[5] = 32'h1FC;

    bp_if.lookup_valid_i = 0; bp_if.lookup_pc_i = 0; bp_if.PL_stall = 0;
    bp_if.update_valid_i = 0; bp_if.update_pc_i = 0; bp_if.update_taken_i = 0;
    bp_if.update_mispredict_i = 0; bp_if.update_history_i = 0;
    do_reset();

    // reset defaults
    step("rst_lookup", 0, 1, 32'h40, 0, 0, 0, 0, 0, 0);

    // saturation on PC 0x100
    step("sat_t1", 0, 0, 32'h100, 0, 1, 32'h100, 1, 0, 0);
    step("sat_t2", 0, 1, 32'h100, 0, 1, 32'h100, 1, 0, 0);
    step("sat_t3", 0, 0, 32'h100, 0, 1, 32'h100, 1, 0, 0);
    step("sat_rd", 0, 1, 32'h100, 1, 0, 0, 0, 0, 0);
    step("sat_n1", 0, 0, 32'h100, 0, 1, 32'h100, 0, 1, 0);
    step("sat_n2", 0, 0, 32'h100, 0, 1, 32'h100, 0, 0, 0);
    step("sat_rd0", 0, 1, 32'h100, 1, 0, 0, 0, 0, 0);

    // same-cycle update and lookup: no bypass
    step("conf_same", 0, 1, 32'h100, 1, 1, 32'h100, 1, 0, 0);
    step("conf_next", 0, 1, 32'h100, 1, 0, 0, 0, 0, 0);

    // aliasing: 0x200 shares 0x100's index, 0x104 does not
    do_reset();
    step("alias_t1", 0, 0, 0, 0, 1, 32'h100, 1, 0, 0);
    step("alias_t2", 0, 0, 0, 0, 1, 32'h100, 1, 0, 0);
    step("alias_200", 0, 1, 32'h200, 1, 0, 0, 0, 0, 0);
    step("alias_104", 0, 1, 32'h104, 1, 0, 0, 0, 0, 0);

    // stall keeps history, unstalled lookup shifts, repair wins
    do_reset();
    step("gh_train", 0, 0, 0, 0, 1, 32'h300, 1, 0, 0);
    step("gh_stall", 0, 1, 32'h300, 1, 0, 0, 0, 0, 0);
    step("gh_go",    0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
    step("gh_rep",   0, 1, 32'h300, 0, 1, 32'h300, 0, 1, 6'd0);
    step("gh_after", 0, 1, 32'h104, 1, 0, 0, 0, 0, 0);

    // reset overrides concurrent lookup and update
    step("mid_rst", 1, 1, 32'h100, 0, 1, 32'h100, 1, 1, 6'h3F);
    step("post_rst", 0, 1, 32'h100, 1, 0, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      step("rand", 0, 1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)],
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    end

    // branch counter wrap
    @(negedge clk);
    bp_if.lookup_valid_i = 0; bp_if.update_valid_i = 0; bp_if.update_mispredict_i = 0;
    force dut.branch_cnt_d = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.branch_cnt_d;
    m_bc = 32'hFFFF_FFFF;
    step("wrap_pre",  0, 0, 0, 0, 1, 32'h104, 0, 1, 0);
    step("wrap_post", 0, 0, 0, 0, 0, 32'h104, 0, 1, 0);
    step("mp_only",   0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
